// File: rtl/llc_output_encoder.sv
// -----------------------------------------------------------------------------
// llc_output_encoder
// Outbound message buffer for the LLC control FSM. Four independent channels
// (rsp_out, fwd_out, mem_req, dma_rsp_out) each own a small FIFO, so
// backpressure on one channel stalls the FSM only when it sends on that channel.
//
// Ports (per channel <ch>):
//   send_<ch>, send_<ch>_data   FSM push request and payload
//   <ch>_ready_for_send         FIFO not full (from registered count only)
//   llc_<ch>_valid / _ready     head handshake toward NoC / memory
//   llc_<ch>                    head payload
// Common:
//   clk, rst (async, active low), overflow_err (sticky), idle
//
// Optional build macro LLC_OUT_PERF_EN adds clr_perf and stall_cnt_<ch>[15:0],
// saturating counts of cycles where a channel head is valid but not accepted.
// -----------------------------------------------------------------------------

module llc_out_fifo #(
    parameter int DEPTH = 2,
    parameter int W     = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push_req,
    input  logic [W-1:0] push_data,
    output logic         ready_for_send,
    output logic         valid,
    input  logic         pop_ready,
    output logic [W-1:0] head,
`ifdef LLC_OUT_PERF_EN
    input  logic         clr_perf,
    output logic [15:0]  stall_cnt,
`endif
    output logic         push_drop
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [W-1:0]  mem [DEPTH];
    logic [PW-1:0] rptr;
    logic [PW-1:0] wptr;
    logic [CW-1:0] count;
    logic          full;
    logic          push;
    logic          pop;

    // A same-cycle pop never frees the slot for a push: full looks at the
    // registered count only.
    assign full           = (count == CW'(DEPTH));
    assign ready_for_send = !full;
    assign valid          = (count != '0);
    assign push           = push_req && !full;
    assign pop            = valid && pop_ready;
    assign push_drop      = push_req && full;
    assign head           = mem[rptr];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rptr  <= '0;
            wptr  <= '0;
            count <= '0;
        end else begin
            if (push) wptr <= wptr + PW'(1);
            if (pop)  rptr <= rptr + PW'(1);
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Payload storage is deliberately left unreset.
    always_ff @(posedge clk) begin
        if (push) mem[wptr] <= push_data;
    end

`ifdef LLC_OUT_PERF_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_cnt <= '0;
        end else if (clr_perf) begin
            stall_cnt <= '0;
        end else if (valid && !pop_ready && (stall_cnt != '1)) begin
            stall_cnt <= stall_cnt + 16'd1;
        end
    end
`endif
endmodule

module llc_output_encoder #(
    parameter int DEPTH = 2,
    parameter int RSP_W = 64,
    parameter int FWD_W = 48,
    parameter int MEM_W = 96,
    parameter int DMA_W = 80
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             send_rsp_out,
    input  logic [RSP_W-1:0] send_rsp_out_data,
    output logic             rsp_out_ready_for_send,
    output logic             llc_rsp_out_valid,
    input  logic             llc_rsp_out_ready,
    output logic [RSP_W-1:0] llc_rsp_out,
    input  logic             send_fwd_out,
    input  logic [FWD_W-1:0] send_fwd_out_data,
    output logic             fwd_out_ready_for_send,
    output logic             llc_fwd_out_valid,
    input  logic             llc_fwd_out_ready,
    output logic [FWD_W-1:0] llc_fwd_out,
    input  logic             send_mem_req,
    input  logic [MEM_W-1:0] send_mem_req_data,
    output logic             mem_req_ready_for_send,
    output logic             llc_mem_req_valid,
    input  logic             llc_mem_req_ready,
    output logic [MEM_W-1:0] llc_mem_req,
    input  logic             send_dma_rsp_out,
    input  logic [DMA_W-1:0] send_dma_rsp_out_data,
    output logic             dma_rsp_out_ready_for_send,
    output logic             llc_dma_rsp_out_valid,
    input  logic             llc_dma_rsp_out_ready,
    output logic [DMA_W-1:0] llc_dma_rsp_out,
`ifdef LLC_OUT_PERF_EN
    input  logic             clr_perf,
    output logic [15:0]      stall_cnt_rsp_out,
    output logic [15:0]      stall_cnt_fwd_out,
    output logic [15:0]      stall_cnt_mem_req,
    output logic [15:0]      stall_cnt_dma_rsp_out,
`endif
    output logic             overflow_err,
    output logic             idle
);
    logic [3:0] drop;

    llc_out_fifo #(.DEPTH(DEPTH), .W(RSP_W)) u_rsp_out (
        .clk(clk), .rst(rst),
        .push_req(send_rsp_out), .push_data(send_rsp_out_data),
        .ready_for_send(rsp_out_ready_for_send),
        .valid(llc_rsp_out_valid), .pop_ready(llc_rsp_out_ready), .head(llc_rsp_out),
`ifdef LLC_OUT_PERF_EN
        .clr_perf(clr_perf), .stall_cnt(stall_cnt_rsp_out),
`endif
        .push_drop(drop[0])
    );

    llc_out_fifo #(.DEPTH(DEPTH), .W(FWD_W)) u_fwd_out (
        .clk(clk), .rst(rst),
        .push_req(send_fwd_out), .push_data(send_fwd_out_data),
        .ready_for_send(fwd_out_ready_for_send),
        .valid(llc_fwd_out_valid), .pop_ready(llc_fwd_out_ready), .head(llc_fwd_out),
`ifdef LLC_OUT_PERF_EN
        .clr_perf(clr_perf), .stall_cnt(stall_cnt_fwd_out),
`endif
        .push_drop(drop[1])
    );

    llc_out_fifo #(.DEPTH(DEPTH), .W(MEM_W)) u_mem_req (
        .clk(clk), .rst(rst),
        .push_req(send_mem_req), .push_data(send_mem_req_data),
        .ready_for_send(mem_req_ready_for_send),
        .valid(llc_mem_req_valid), .pop_ready(llc_mem_req_ready), .head(llc_mem_req),
`ifdef LLC_OUT_PERF_EN
        .clr_perf(clr_perf), .stall_cnt(stall_cnt_mem_req),
`endif
        .push_drop(drop[2])
    );

    llc_out_fifo #(.DEPTH(DEPTH), .W(DMA_W)) u_dma_rsp_out (
        .clk(clk), .rst(rst),
        .push_req(send_dma_rsp_out), .push_data(send_dma_rsp_out_data),
        .ready_for_send(dma_rsp_out_ready_for_send),
        .valid(llc_dma_rsp_out_valid), .pop_ready(llc_dma_rsp_out_ready), .head(llc_dma_rsp_out),
`ifdef LLC_OUT_PERF_EN
        .clr_perf(clr_perf), .stall_cnt(stall_cnt_dma_rsp_out),
`endif
        .push_drop(drop[3])
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            overflow_err <= 1'b0;
        end else if (|drop) begin
            overflow_err <= 1'b1;
        end
    end

    // An empty FIFO has valid low, so "no valids" means all counts are zero.
    always_comb begin
        idle = !(llc_rsp_out_valid || llc_fwd_out_valid ||
                 llc_mem_req_valid || llc_dma_rsp_out_valid ||
                 send_rsp_out || send_fwd_out || send_mem_req || send_dma_rsp_out);
    end
endmodule

// File: tb/tb_llc_output_encoder.sv
module tb_llc_output_encoder;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [3:0]  snd = '0;
    logic [3:0]  rdy = '0;
    logic [95:0] sdata [4];
    logic [63:0] o_rsp;
    logic [47:0] o_fwd;
    logic [95:0] o_mem;
    logic [79:0] o_dma;
    logic [3:0]  vld;
    logic [3:0]  rfs;
    logic        ovf;
    logic        idle;
    logic [95:0] hd [4];
`ifdef LLC_OUT_PERF_EN
    logic        clr_perf = 1'b0;
    logic [15:0] sc0, sc1, sc2, sc3;
`endif

    llc_output_encoder #(
        .DEPTH(2), .RSP_W(64), .FWD_W(48), .MEM_W(96), .DMA_W(80)
    ) dut (
        .clk(clk), .rst(rst),
        .send_rsp_out(snd[0]), .send_rsp_out_data(sdata[0][63:0]),
        .rsp_out_ready_for_send(rfs[0]), .llc_rsp_out_valid(vld[0]),
        .llc_rsp_out_ready(rdy[0]), .llc_rsp_out(o_rsp),
        .send_fwd_out(snd[1]), .send_fwd_out_data(sdata[1][47:0]),
        .fwd_out_ready_for_send(rfs[1]), .llc_fwd_out_valid(vld[1]),
        .llc_fwd_out_ready(rdy[1]), .llc_fwd_out(o_fwd),
        .send_mem_req(snd[2]), .send_mem_req_data(sdata[2]),
        .mem_req_ready_for_send(rfs[2]), .llc_mem_req_valid(vld[2]),
        .llc_mem_req_ready(rdy[2]), .llc_mem_req(o_mem),
        .send_dma_rsp_out(snd[3]), .send_dma_rsp_out_data(sdata[3][79:0]),
        .dma_rsp_out_ready_for_send(rfs[3]), .llc_dma_rsp_out_valid(vld[3]),
        .llc_dma_rsp_out_ready(rdy[3]), .llc_dma_rsp_out(o_dma),
`ifdef LLC_OUT_PERF_EN
        .clr_perf(clr_perf),
        .stall_cnt_rsp_out(sc0), .stall_cnt_fwd_out(sc1),
        .stall_cnt_mem_req(sc2), .stall_cnt_dma_rsp_out(sc3),
`endif
        .overflow_err(ovf), .idle(idle)
    );

    assign hd[0] = {32'b0, o_rsp};
    assign hd[1] = {48'b0, o_fwd};
    assign hd[2] = o_mem;
    assign hd[3] = {16'b0, o_dma};

    int total = 0;
    int bad   = 0;

    // Reference model: per channel, the log of accepted messages; entries
    // between mh and mt are still queued, oldest first.
    logic [95:0] mbuf [4][256];
    int unsigned mh [4];
    int unsigned mt [4];
    bit          movf;
    localparam int unsigned CAP = 2;

    function automatic int unsigned msize(int c);
        return mt[c] - mh[c];
    endfunction

    function automatic logic [95:0] wmask(int c);
        logic [95:0] m;
        m = '1;
        case (c)
            0: m = m >> 32;
            1: m = m >> 48;
            3: m = m >> 16;
            default: ;
        endcase
        return m;
    endfunction

    function automatic logic [95:0] rnd_data(int c);
        logic [95:0] d;
        d = {$urandom, $urandom, $urandom};
        return d & wmask(c);
    endfunction

    task automatic model_reset();
        for (int c = 0; c < 4; c++) begin
            mh[c] = 0;
            mt[c] = 0;
        end
        movf = 1'b0;
    endtask

    // Applies the spec rules for the inputs currently driven, then clocks.
    task automatic advance();
        bit do_pop [4];
        bit do_push [4];
        bit ovf_n;
        ovf_n = movf;
        for (int c = 0; c < 4; c++) begin
            do_pop[c]  = (msize(c) != 0) && rdy[c];
            do_push[c] = snd[c] && (msize(c) != CAP);
            if (snd[c] && msize(c) == CAP) ovf_n = 1'b1;
        end
        @(posedge clk);
        #1;
        for (int c = 0; c < 4; c++) begin
            if (do_pop[c]) mh[c]++;
            if (do_push[c]) begin
                mbuf[c][mt[c] % 256] = sdata[c] & wmask(c);
                mt[c]++;
            end
        end
        movf = ovf_n;
    endtask

    task automatic drain();
        snd = '0;
        rdy = '1;
        repeat (4) advance();
        rdy = '0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        #2 rst = 1'b0;
        model_reset();
        for (int c = 0; c < 4; c++) sdata[c] = '0;
        repeat (2) @(posedge clk);
        @(negedge clk) rst = 1'b1;
        @(posedge clk);
        #1;
        total++; if (vld !== 4'h0) begin bad++; $display("FAIL reset_valid got=%b exp=0000", vld); end
        total++; if (rfs !== 4'hF) begin bad++; $display("FAIL reset_rfs got=%b exp=1111", rfs); end
        total++; if (idle !== 1'b1) begin bad++; $display("FAIL reset_idle got=%b exp=1", idle); end
        total++; if (ovf !== 1'b0) begin bad++; $display("FAIL reset_ovf got=%b exp=0", ovf); end
        snd[0] = 1'b1;
        sdata[0] = 96'hA5;
        #1;
        total++; if (idle !== 1'b0) begin bad++; $display("FAIL idle_with_send got=%b exp=0", idle); end
        advance();
        snd = '0;
        total++; if (vld !== 4'b0001) begin bad++; $display("FAIL first_push_valid got=%b exp=0001", vld); end
        total++; if (hd[0] !== 96'hA5) begin bad++; $display("FAIL first_push_data got=%h exp=a5", hd[0]); end
        total++; if (idle !== 1'b0) begin bad++; $display("FAIL first_push_idle got=%b exp=0", idle); end
        drain();
        total++; if (idle !== 1'b1) begin bad++; $display("FAIL drained_idle got=%b exp=1", idle); end
    endtask

    task automatic test_overflow();
        logic [95:0] got [4];
        int n;
        n = 0;
        rdy = '0;
        snd[2] = 1'b1; sdata[2] = 96'h1; advance();
        sdata[2] = 96'h2; advance();
        snd[2] = 1'b0;
        total++; if (rfs[2] !== 1'b0) begin bad++; $display("FAIL mem_full_rfs got=%b exp=0", rfs[2]); end
        total++; if (ovf !== 1'b0) begin bad++; $display("FAIL ovf_before_drop got=%b exp=0", ovf); end
        snd[2] = 1'b1; sdata[2] = 96'h3; advance();
        snd[2] = 1'b0;
        total++; if (ovf !== 1'b1) begin bad++; $display("FAIL ovf_after_drop got=%b exp=1", ovf); end
        total++; if (hd[2] !== 96'h1 || vld[2] !== 1'b1) begin bad++; $display("FAIL mem_head_stable got=%h/%b exp=1/1", hd[2], vld[2]); end
        rdy[2] = 1'b1;
        for (int i = 0; i < 6; i++) begin
            if (vld[2] && n < 4) begin got[n] = hd[2]; n++; end
            advance();
        end
        rdy[2] = 1'b0;
        total++; if (n !== 2) begin bad++; $display("FAIL mem_deliver_count got=%0d exp=2", n); end
        total++; if (n >= 2 && (got[0] !== 96'h1 || got[1] !== 96'h2)) begin bad++; $display("FAIL mem_deliver_order got=%h,%h exp=1,2", got[0], got[1]); end
        total++; if (ovf !== 1'b1) begin bad++; $display("FAIL ovf_sticky got=%b exp=1", ovf); end
    endtask

    task automatic test_full_pop_push();
        rdy = '0;
        snd[1] = 1'b1; sdata[1] = 96'h11; advance();
        sdata[1] = 96'h22; advance();
        sdata[1] = 96'h33; rdy[1] = 1'b1;
        total++; if (rfs[1] !== 1'b0) begin bad++; $display("FAIL fwd_full_rfs got=%b exp=0", rfs[1]); end
        advance();
        snd = '0; rdy = '0;
        total++; if (vld[1] !== 1'b1 || hd[1] !== 96'h22) begin bad++; $display("FAIL fwd_after_pop got=%b/%h exp=1/22", vld[1], hd[1]); end
        total++; if (rfs[1] !== 1'b1) begin bad++; $display("FAIL fwd_rfs_reopen got=%b exp=1", rfs[1]); end
        rdy[1] = 1'b1;
        advance();
        rdy = '0;
        total++; if (vld[1] !== 1'b0) begin bad++; $display("FAIL fwd_pushed_while_full got=%b exp=0", vld[1]); end
    endtask

    task automatic test_all_channels();
        logic [95:0] items [4][8];
        int pushed [4];
        int got [4];
        for (int c = 0; c < 4; c++) begin
            pushed[c] = 0;
            got[c] = 0;
            for (int k = 0; k < 8; k++) items[c][k] = rnd_data(c);
        end
        for (int cyc = 0; cyc < 80; cyc++) begin
            rdy = (cyc % 2 == 0) ? 4'hF : 4'h0;
            for (int c = 0; c < 4; c++) begin
                snd[c] = (pushed[c] < 8) && (msize(c) < CAP);
                sdata[c] = items[c][pushed[c] % 8];
            end
            if (cyc == 0) begin
                total++; if (snd !== 4'hF) begin bad++; $display("FAIL all_push_first_cycle got=%b exp=1111", snd); end
            end
            for (int c = 0; c < 4; c++) begin
                if (vld[c] && rdy[c] && got[c] < 8) begin
                    total++;
                    if (hd[c] !== items[c][got[c]]) begin
                        bad++;
                        $display("FAIL multi_ch%0d_item%0d got=%h exp=%h", c, got[c], hd[c], items[c][got[c]]);
                    end
                    got[c]++;
                end
            end
            advance();
            for (int c = 0; c < 4; c++) if (snd[c]) pushed[c]++;
        end
        snd = '0; rdy = '0;
        for (int c = 0; c < 4; c++) begin
            total++; if (got[c] !== 8) begin bad++; $display("FAIL multi_ch%0d_count got=%0d exp=8", c, got[c]); end
        end
    endtask

    task automatic test_async_reset();
        rdy = '0;
        snd[3] = 1'b1; sdata[3] = rnd_data(3); advance();
        sdata[3] = rnd_data(3); advance();
        snd = '0;
        total++; if (vld[3] !== 1'b1) begin bad++; $display("FAIL dma_queued got=%b exp=1", vld[3]); end
        #2 rst = 1'b0;
        #1;
        total++; if (vld[3] !== 1'b0) begin bad++; $display("FAIL dma_valid_in_reset got=%b exp=0", vld[3]); end
        total++; if (rfs !== 4'hF) begin bad++; $display("FAIL rfs_in_reset got=%b exp=1111", rfs); end
        @(negedge clk) rst = 1'b1;
        model_reset();
        @(posedge clk);
        #1;
        total++; if (vld !== 4'h0 || idle !== 1'b1) begin bad++; $display("FAIL after_reset_empty got=%b/%b exp=0000/1", vld, idle); end
        total++; if (ovf !== 1'b0) begin bad++; $display("FAIL after_reset_ovf got=%b exp=0", ovf); end
    endtask

    task automatic test_random();
        bit exp_idle;
        for (int cyc = 0; cyc < 400; cyc++) begin
            snd = 4'($urandom);
            rdy = 4'($urandom);
            for (int c = 0; c < 4; c++) sdata[c] = rnd_data(c);
            #1;
            exp_idle = (snd == 4'h0);
            for (int c = 0; c < 4; c++) begin
                if (msize(c) != 0) exp_idle = 1'b0;
                total++;
                if (vld[c] !== (msize(c) != 0)) begin bad++; $display("FAIL rnd_valid ch%0d cyc%0d got=%b exp=%b", c, cyc, vld[c], msize(c) != 0); end
                total++;
                if (rfs[c] !== (msize(c) != CAP)) begin bad++; $display("FAIL rnd_rfs ch%0d cyc%0d got=%b exp=%b", c, cyc, rfs[c], msize(c) != CAP); end
                if (msize(c) != 0) begin
                    total++;
                    if (hd[c] !== mbuf[c][mh[c] % 256]) begin bad++; $display("FAIL rnd_head ch%0d cyc%0d got=%h exp=%h", c, cyc, hd[c], mbuf[c][mh[c] % 256]); end
                end
            end
            total++; if (idle !== exp_idle) begin bad++; $display("FAIL rnd_idle cyc%0d got=%b exp=%b", cyc, idle, exp_idle); end
            total++; if (ovf !== movf) begin bad++; $display("FAIL rnd_ovf cyc%0d got=%b exp=%b", cyc, ovf, movf); end
            advance();
        end
        drain();
    endtask

`ifdef LLC_OUT_PERF_EN
    task automatic test_perf();
        drain();
        clr_perf = 1'b1; advance(); clr_perf = 1'b0;
        snd[0] = 1'b1; sdata[0] = 96'h5A; rdy = '0; advance();
        snd = '0;
        repeat (10) advance();
        total++; if (sc0 !== 16'd10) begin bad++; $display("FAIL stall_cnt_10 got=%0d exp=10", sc0); end
        total++; if ({sc1, sc2, sc3} !== 48'd0) begin bad++; $display("FAIL stall_other_ch got=%h exp=0", {sc1, sc2, sc3}); end
        clr_perf = 1'b1; advance(); clr_perf = 1'b0;
        total++; if (sc0 !== 16'd0) begin bad++; $display("FAIL stall_clear got=%0d exp=0", sc0); end
        repeat (70000) @(posedge clk);
        #1;
        total++; if (sc0 !== 16'hFFFF) begin bad++; $display("FAIL stall_saturate got=%h exp=ffff", sc0); end
        drain();
    endtask
`endif

    initial begin
        test_reset();
        test_overflow();
        test_full_pop_push();
        test_all_channels();
        test_async_reset();
        test_random();
`ifdef LLC_OUT_PERF_EN
        test_perf();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
